text_scanout: RTL and testbench

- Read-side counterpart of the text-buffer write port.
- Converts a raster pixel position stream into pixel colours. For each pixel it:
  - fetches the 18-bit text cell from the text buffer read port,
  - fetches the glyph row from the font ROM,
  - applies the FG/BG/blink attributes and maps the result through a 16-entry palette to 24-bit RGB.
- Sits between the video timing generator and the TMDS encoders inside the TextGraphic path.
- Cell format, shared with the writer: {BL[17:16], BG[15:12], FG[11:8], CHAR[7:0]}. Address = row*COLS + col.

---
 rtl/xrc_text_pkg.sv | 52 +++++
 rtl/text_palette.sv | 44 ++++
 rtl/text_scanout.sv | 133 +++++++++++++
 tb/tb_text_scanout.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xrc_text_pkg.sv
// rtl/xrc_text_pkg.sv - text cell layout, blink/reverse encodings and grid defaults
// Shared by the text-buffer writer and the scanout read path.
`timescale 1ns/1ps
package xrc_text_pkg;

    localparam int ADDR_W    = 13;
    localparam int DEF_COLS  = 120;
    localparam int DEF_ROWS  = 61;
    localparam int CELL_BITS = 18;

    // Cell layout {BL[17:16], BG[15:12], FG[11:8], CHAR[7:0]}
    localparam int CHAR_LO = 0;
    localparam int CHAR_W  = 8;
    localparam int FG_LO   = 8;
    localparam int FG_W    = 4;
    localparam int BG_LO   = 12;
    localparam int BG_W    = 4;
    localparam int BL_LO   = 16;
    localparam int BL_W    = 2;

    typedef enum logic [1:0] {
        BL_NORMAL   = 2'b00,
        BL_BLINK    = 2'b01,
        BL_REVERSE  = 2'b10,
        BL_REVBLINK = 2'b11
    } bl_e;

    // Palette index of one glyph pixel given its cell attributes and the
    // frame counter (bit 5 gates blink, bit 4 gates reverse-blink).
    function automatic logic [3:0] attr_index(
        input logic [1:0] bl,
        input logic [3:0] fg,
        input logic [3:0] bg,
        input logic       lit,
        input logic [5:0] frame_cnt
    );
        logic [3:0] fg_eff;
        logic       rev;
        fg_eff = fg;
        rev    = 1'b0;
        case (bl)
            BL_NORMAL:   rev = 1'b0;
            BL_BLINK:    if (frame_cnt[5]) fg_eff = bg;
            BL_REVERSE:  rev = 1'b1;
            default:     rev = frame_cnt[4];
        endcase
        if (rev)
            return lit ? bg : fg_eff;
        return lit ? fg_eff : bg;
    endfunction

endpackage

// File: rtl/text_palette.sv
// rtl/text_palette.sv - registered 16-entry CGA palette (4-bit index to 24-bit RGB)
// Ports: clk, rst_n (async active-low), idx palette index, en pixel enable
//        (output forced to black when low), rgb registered {R,G,B}.
`timescale 1ns/1ps
module text_palette (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  idx,
    input  logic        en,
    output logic [23:0] rgb
);

    logic [23:0] lut;

    always_comb begin
        lut = 24'h000000;
        case (idx)
            4'h0: lut = 24'h000000;
            4'h1: lut = 24'h0000AA;
            4'h2: lut = 24'h00AA00;
            4'h3: lut = 24'h00AAAA;
            4'h4: lut = 24'hAA0000;
            4'h5: lut = 24'hAA00AA;
            4'h6: lut = 24'hAA5500;
            4'h7: lut = 24'hAAAAAA;
            4'h8: lut = 24'h555555;
            4'h9: lut = 24'h5555FF;
            4'hA: lut = 24'h55FF55;
            4'hB: lut = 24'h55FFFF;
            4'hC: lut = 24'hFF5555;
            4'hD: lut = 24'hFF55FF;
            4'hE: lut = 24'hFFFF55;
            default: lut = 24'hFFFFFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rgb <= 24'h000000;
        else
            rgb <= en ? lut : 24'h000000;
    end

endmodule

// File: rtl/text_scanout.sv
// rtl/text_scanout.sv - 5-stage text-mode scanout: pixel position to RGB
// Ports: clk50/rst_n; PixX/PixY/PixDe raster position and qualifier;
//        HSyncIn/VSyncIn syncs; RAddr/RData text buffer read port;
//        FAddr/FData font ROM port; Rgb/De/HSync/VSync outputs, 5 cycles
//        behind the inputs.
`timescale 1ns/1ps
module text_scanout
    import xrc_text_pkg::*;
#(
    parameter int         COLS        = DEF_COLS,
    parameter int         ROWS        = DEF_ROWS,
    parameter int         CELL_W_LOG2 = 3,
    parameter int         CELL_H_LOG2 = 3,
    parameter logic [3:0] BORDER_IDX  = 4'd0
) (
    input  logic                 clk50,
    input  logic                 rst_n,
    input  logic [10:0]          PixX,
    input  logic [10:0]          PixY,
    input  logic                 PixDe,
    input  logic                 HSyncIn,
    input  logic                 VSyncIn,
    output logic [ADDR_W-1:0]    RAddr,
    input  logic [CELL_BITS-1:0] RData,
    output logic [10:0]          FAddr,
    input  logic [7:0]           FData,
    output logic [23:0]          Rgb,
    output logic                 De,
    output logic                 HSync,
    output logic                 VSync
);

    logic [10:0]             col;
    logic [10:0]             row;
    logic                    in_grid;
    logic [ADDR_W-1:0]       addr_next;

    // Stage registers; the digit is the stage that produced them.
    logic [CELL_W_LOG2-1:0]  xs1, xs2;
    logic [CELL_H_LOG2-1:0]  ys1;
    logic                    g1, g2, g3;
    logic [BL_W-1:0]         bl2, bl3;
    logic [FG_W-1:0]         fg2, fg3;
    logic [BG_W-1:0]         bg2, bg3;
    logic                    lit3;
    logic [3:0]              idx4;

    logic [4:0]              de_sr, hs_sr, vs_sr;
    logic [5:0]              frame_cnt;

    assign col       = PixX >> CELL_W_LOG2;
    assign row       = PixY >> CELL_H_LOG2;
    assign in_grid   = PixDe && (col < 11'(COLS)) && (row < 11'(ROWS));
    // Only used when in_grid, so the product never reaches ROWS*COLS.
    assign addr_next = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            RAddr     <= '0;
            FAddr     <= '0;
            xs1       <= '0;
            xs2       <= '0;
            ys1       <= '0;
            g1        <= 1'b0;
            g2        <= 1'b0;
            g3        <= 1'b0;
            bl2       <= '0;
            bl3       <= '0;
            fg2       <= '0;
            fg3       <= '0;
            bg2       <= '0;
            bg3       <= '0;
            lit3      <= 1'b0;
            idx4      <= '0;
            de_sr     <= '0;
            hs_sr     <= '0;
            vs_sr     <= '0;
            frame_cnt <= '0;
        end else begin
            // S1: cell address; hold the last address for off-grid pixels
            if (in_grid)
                RAddr <= addr_next;
            xs1 <= PixX[CELL_W_LOG2-1:0];
            ys1 <= PixY[CELL_H_LOG2-1:0];
            g1  <= in_grid;

            // S2: cell arrives; the glyph row address is formed straight from RData
            FAddr <= {RData[CHAR_LO +: CHAR_W], ys1};
            bl2   <= RData[BL_LO +: BL_W];
            fg2   <= RData[FG_LO +: FG_W];
            bg2   <= RData[BG_LO +: BG_W];
            xs2   <= xs1;
            g2    <= g1;

            // S3: glyph row arrives; bit 7 is leftmost, so index with 7-x == ~x
            lit3 <= FData[~xs2];
            bl3  <= bl2;
            fg3  <= fg2;
            bg3  <= bg2;
            g3   <= g2;

            // S4: palette index
            if (!de_sr[2])
                idx4 <= 4'd0;
            else if (!g3)
                idx4 <= BORDER_IDX;
            else
                idx4 <= attr_index(bl3, fg3, bg3, lit3, frame_cnt);

            de_sr <= {de_sr[3:0], PixDe};
            hs_sr <= {hs_sr[3:0], HSyncIn};
            vs_sr <= {vs_sr[3:0], VSyncIn};

            // vs_sr[0] is last cycle's VSyncIn, so this is the rising edge
            if (VSyncIn && !vs_sr[0])
                frame_cnt <= frame_cnt + 6'd1;
        end
    end

    // S5
    text_palette u_palette (
        .clk   (clk50),
        .rst_n (rst_n),
        .idx   (idx4),
        .en    (de_sr[3]),
        .rgb   (Rgb)
    );

    assign De    = de_sr[4];
    assign HSync = hs_sr[4];
    assign VSync = vs_sr[4];

endmodule

// File: tb/tb_text_scanout.sv
// tb/tb_text_scanout.sv - randomized self-checking bench for text_scanout
`timescale 1ns/1ps
module tb_text_scanout;

    logic        clk50 = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] PixX = '0;
    logic [10:0] PixY = '0;
    logic        PixDe = 1'b0;
    logic        HSyncIn = 1'b0;
    logic        VSyncIn = 1'b0;
    logic [12:0] RAddr;
    logic [17:0] RData;
    logic [10:0] FAddr;
    logic [7:0]  FData;
    logic [23:0] Rgb;
    logic        De;
    logic        HSync;
    logic        VSync;

    always #10 clk50 = ~clk50;

    text_scanout dut (
        .clk50   (clk50),
        .rst_n   (rst_n),
        .PixX    (PixX),
        .PixY    (PixY),
        .PixDe   (PixDe),
        .HSyncIn (HSyncIn),
        .VSyncIn (VSyncIn),
        .RAddr   (RAddr),
        .RData   (RData),
        .FAddr   (FAddr),
        .FData   (FData),
        .Rgb     (Rgb),
        .De      (De),
        .HSync   (HSync),
        .VSync   (VSync)
    );

    // Memories read combinationally from the registered addresses: data is
    // valid the cycle after the address.
    logic [17:0] tbuf [0:8191];
    logic [7:0]  font [0:2047];
    assign RData = tbuf[RAddr];
    assign FData = font[FAddr];

    logic [23:0] pal [16] = '{24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
                              24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
                              24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
                              24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF};

    typedef struct packed {
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
    } out_t;

    out_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   frame_m = 0;
    logic vs_m = 1'b0;

    // Reference: colour of one pixel from the grid rules, straight from memory
    function automatic logic [23:0] model_px(input logic [10:0] x, input logic [10:0] y,
                                             input logic de, input int frame);
        int         col, row, xs;
        logic [17:0] c;
        logic [7:0]  g;
        logic [3:0]  fg, bg, idx;
        logic        lit, rev;
        if (!de) return 24'h0;
        col = int'(x) / 8;
        row = int'(y) / 8;
        if (col >= 120 || row >= 61) return pal[0];
        c   = tbuf[row * 120 + col];
        g   = font[{c[7:0], y[2:0]}];
        xs  = int'(x) % 8;
        lit = g[7 - xs];
        fg  = c[11:8];
        bg  = c[15:12];
        rev = 1'b0;
        if (c[17:16] == 2'b01 && ((frame / 32) % 2) == 1) fg = bg;
        if (c[17:16] == 2'b10) rev = 1'b1;
        if (c[17:16] == 2'b11) rev = ((frame / 16) % 2) == 1;
        if (rev) idx = lit ? bg : fg;
        else     idx = lit ? fg : bg;
        return pal[idx];
    endfunction

    // One pixel clock: sample outputs (answer to the input 5 steps back), drive new input
    task automatic step(input logic [10:0] x, input logic [10:0] y, input logic de,
                        input logic hs, input logic vs, output out_t got, output out_t exp);
        @(negedge clk50);
        got = '{rgb: Rgb, de: De, hs: HSync, vs: VSync};
        exp = q.pop_front();
        PixX = x; PixY = y; PixDe = de; HSyncIn = hs; VSyncIn = vs;
        if (vs && !vs_m) frame_m = (frame_m + 1) % 64;
        vs_m = vs;
        q.push_back('{rgb: model_px(x, y, de, frame_m), de: de, hs: hs, vs: vs});
    endtask

    task automatic release_reset();
        PixX = '0; PixY = '0; PixDe = 1'b0; HSyncIn = 1'b0; VSyncIn = 1'b0;
        rst_n = 1'b1;
        q.delete();
        repeat (5) q.push_back('0);
        frame_m = 0;
        vs_m = 1'b0;
    endtask

    task automatic pulse_vs(input int n);
        out_t g, e;
        repeat (4) step(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, g, e);
        for (int i = 0; i < n; i++) begin
            step(11'd0, 11'd0, 1'b0, 1'b0, 1'b1, g, e);
            step(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, g, e);
        end
    endtask

    task automatic probe(input logic [10:0] x, input logic [10:0] y, output out_t got, output out_t exp);
        out_t g, e;
        step(x, y, 1'b1, 1'b0, 1'b0, g, e);
        for (int i = 0; i < 5; i++) step(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, got, exp);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk50);
        n_cmp++; if (Rgb !== 24'h0)  begin n_fail++; $display("FAIL reset_rgb got=%h exp=0", Rgb); end
        n_cmp++; if (De !== 1'b0)    begin n_fail++; $display("FAIL reset_de got=%b exp=0", De); end
        n_cmp++; if (HSync !== 1'b0) begin n_fail++; $display("FAIL reset_hsync got=%b exp=0", HSync); end
        n_cmp++; if (VSync !== 1'b0) begin n_fail++; $display("FAIL reset_vsync got=%b exp=0", VSync); end
        n_cmp++; if (RAddr !== 13'd0) begin n_fail++; $display("FAIL reset_raddr got=%0d exp=0", RAddr); end
        n_cmp++; if (FAddr !== 11'd0) begin n_fail++; $display("FAIL reset_faddr got=%h exp=0", FAddr); end
        release_reset();
    endtask

    task automatic test_latency();
        out_t got, exp;
        step(11'd0, 11'd0, 1'b1, 1'b0, 1'b0, got, exp);
        for (int k = 1; k <= 6; k++) begin
            step(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, got, exp);
            if (k == 1) begin
                n_cmp++; if (RAddr !== 13'd0) begin n_fail++; $display("FAIL latency_raddr got=%0d exp=0", RAddr); end
            end
            if (k == 2) begin
                n_cmp++; if (FAddr !== 11'h240) begin n_fail++; $display("FAIL latency_faddr got=%h exp=240", FAddr); end
            end
            n_cmp++;
            if (got.de !== (k == 5)) begin n_fail++; $display("FAIL latency_de k=%0d got=%b exp=%b", k, got.de, (k == 5)); end
            if (k == 5) begin
                n_cmp++; if (got.rgb !== 24'hFFFFFF) begin n_fail++; $display("FAIL latency_rgb got=%h exp=FFFFFF", got.rgb); end
            end
        end
    endtask

    task automatic test_pixel_select();
        out_t got, exp;
        logic [23:0] want [8] = '{24'hFFFFFF, 24'hFFFFFF, 24'h0, 24'h0, 24'h0, 24'h0, 24'hFFFFFF, 24'hFFFFFF};
        for (int i = 0; i < 13; i++) begin
            step((i < 8) ? 11'(i) : 11'd0, 11'd0, (i < 8), 1'b0, 1'b0, got, exp);
            if (i >= 5) begin
                n_cmp++;
                if (got.rgb !== want[i-5] || got.de !== 1'b1) begin
                    n_fail++; $display("FAIL pixel_select x=%0d got=%h/%b exp=%h/1", i - 5, got.rgb, got.de, want[i-5]);
                end
            end
        end
    endtask

    task automatic test_addressing();
        out_t got, exp;
        logic [10:0] xs [8] = '{11'd959, 11'd960, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0};
        logic [10:0] ys [8] = '{11'd487, 11'd487, 11'd488, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0};
        for (int i = 0; i < 8; i++) begin
            step(xs[i], ys[i], (i < 3), 1'b0, 1'b0, got, exp);
            if (i >= 1 && i <= 3) begin
                n_cmp++; if (RAddr !== 13'd7319) begin n_fail++; $display("FAIL addr_raddr i=%0d got=%0d exp=7319", i, RAddr); end
            end
            if (i == 5) begin
                n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL addr_last_cell got=%h exp=%h", got, exp); end
            end
            if (i >= 6) begin
                n_cmp++;
                if (got.rgb !== pal[0] || got.de !== 1'b1) begin
                    n_fail++; $display("FAIL addr_border i=%0d got=%h/%b exp=%h/1", i, got.rgb, got.de, pal[0]);
                end
            end
        end
    endtask

    task automatic test_attrs();
        out_t got, exp;
        int          pulses [6] = '{0, 32, 32, 0, 16, 0};
        logic [10:0] xs [6]     = '{11'd8, 11'd16, 11'd16, 11'd24, 11'd24, 11'd26};
        logic [23:0] want [6]   = '{24'h0000AA, 24'h0000AA, 24'hFFFF55, 24'hFFFF55, 24'h0000AA, 24'hFFFF55};
        for (int i = 0; i < 6; i++) begin
            if (pulses[i] > 0) pulse_vs(pulses[i]);
            probe(xs[i], 11'd0, got, exp);
            n_cmp++;
            if (got.rgb !== want[i]) begin n_fail++; $display("FAIL attr case=%0d got=%h exp=%h", i, got.rgb, want[i]); end
            n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL attr_model case=%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_random();
        out_t got, exp;
        for (int b = 0; b < 4; b++) begin
            pulse_vs(int'($urandom_range(0, 40)));
            for (int i = 0; i < 100; i++) begin
                step(11'($urandom_range(0, 1100)), 11'($urandom_range(0, 520)), ($urandom_range(0, 7) != 0),
                     1'($urandom_range(0, 1)), 1'b0, got, exp);
                n_cmp++;
                if (got !== exp) begin n_fail++; $display("FAIL random b=%0d i=%0d got=%h exp=%h", b, i, got, exp); end
            end
        end
    endtask

    task automatic test_sync();
        out_t got, exp;
        for (int i = 0; i < 200; i++) begin
            step(11'($urandom_range(0, 1100)), 11'($urandom_range(0, 520)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), got, exp);
            n_cmp++;
            if ({got.de, got.hs, got.vs} !== {exp.de, exp.hs, exp.vs}) begin
                n_fail++; $display("FAIL sync i=%0d got=%b%b%b exp=%b%b%b", i, got.de, got.hs, got.vs, exp.de, exp.hs, exp.vs);
            end
            if (got.de === 1'b0) begin
                n_cmp++;
                if (got.rgb !== 24'h0) begin n_fail++; $display("FAIL sync_blank i=%0d got=%h exp=0", i, got.rgb); end
            end
        end
    endtask

    task automatic test_mid_reset();
        out_t got, exp;
        pulse_vs((96 - frame_m) % 64);
        probe(11'd16, 11'd0, got, exp);
        n_cmp++; if (got.rgb !== 24'h0000AA) begin n_fail++; $display("FAIL midrst_pre got=%h exp=0000AA", got.rgb); end
        for (int i = 0; i < 6; i++) step(11'(16 + i), 11'd0, 1'b1, 1'b1, 1'b0, got, exp);
        n_cmp++; if (De !== 1'b1 || HSync !== 1'b1) begin n_fail++; $display("FAIL midrst_active got=%b%b exp=11", De, HSync); end
        @(negedge clk50);
        rst_n = 1'b0;
        PixDe = 1'b0; HSyncIn = 1'b0; VSyncIn = 1'b0;
        #1;
        n_cmp++;
        if ({Rgb, De, HSync, VSync} !== 27'd0 || RAddr !== 13'd0 || FAddr !== 11'd0) begin
            n_fail++; $display("FAIL midrst_outputs got=%h/%b%b%b/%0d/%h exp=0", Rgb, De, HSync, VSync, RAddr, FAddr);
        end
        @(negedge clk50);
        release_reset();
        for (int k = 1; k <= 5; k++) begin
            if (k == 1) step(11'd16, 11'd0, 1'b1, 1'b0, 1'b0, got, exp);
            step(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, got, exp);
            n_cmp++;
            if (got.de !== (k == 5)) begin n_fail++; $display("FAIL midrst_lat k=%0d got=%b exp=%b", k, got.de, (k == 5)); end
        end
        n_cmp++; if (got.rgb !== 24'hFFFF55) begin n_fail++; $display("FAIL midrst_frame got=%h exp=FFFF55", got.rgb); end
        n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL midrst_model got=%h exp=%h", got, exp); end
    endtask

    initial begin
        #(20_000_000);
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8192; i++) tbuf[i] = 18'($urandom);
        for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);
        tbuf[0] = 18'h00F48;
        tbuf[1] = 18'h21E48;
        tbuf[2] = 18'h11E48;
        tbuf[3] = 18'h31E48;
        font[11'h240] = 8'hC3;

        test_reset();
        test_latency();
        test_pixel_select();
        test_addressing();
        test_attrs();
        test_random();
        test_sync();
        test_mid_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
